// File: rtl/pipe_reg_chain.sv
// Elastic pipeline register: DEPTH stages of WIDTH-bit data with per-stage valid and bubble collapse.
// Optional macro PIPE_REG_OCC_EN adds a registered Occupancy output (count of valid stages).
module pipe_reg_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             En,
    input  logic             Flush,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] Data_in,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Data_out
`ifdef PIPE_REG_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] Occupancy
`endif
);

    logic [DEPTH-1:0] v_reg;
    logic [DEPTH-1:0] v_next;
    logic [WIDTH-1:0] d_reg  [DEPTH];
    logic [WIDTH-1:0] d_next [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] up_v;
    logic [WIDTH-1:0] up_d   [DEPTH];

    // A stage can take data when the consumer is ready or any stage from it
    // to the output is empty; closed form avoids a combinational chain.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            assign rdy[gi] = Out_ready || !(&v_reg[DEPTH-1:gi]);
            if (gi == 0) begin : g_first
                assign up_v[gi] = In_valid;
                assign up_d[gi] = Data_in;
            end else begin : g_rest
                assign up_v[gi] = v_reg[gi-1];
                assign up_d[gi] = d_reg[gi-1];
            end
        end
    endgenerate

    always_comb begin
        v_next = v_reg;
        d_next = d_reg;
        if (Flush) begin
            v_next = '0;
        end else if (En) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    v_next[i] = up_v[i];
                    if (up_v[i]) begin
                        d_next[i] = up_d[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            v_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_reg[i] <= '0;
            end
        end else begin
            v_reg <= v_next;
            for (int i = 0; i < DEPTH; i++) begin
                d_reg[i] <= d_next[i];
            end
        end
    end

    // Reset term keeps In_ready low while the empty pipeline is held in reset.
    assign In_ready  = Reset && En && !Flush && rdy[0];
    assign Out_valid = En && !Flush && v_reg[DEPTH-1];
    assign Data_out  = d_reg[DEPTH-1];

`ifdef PIPE_REG_OCC_EN
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [OCC_W-1:0] occ_reg;
    logic [OCC_W-1:0] occ_next;

    always_comb begin
        occ_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_next = occ_next + OCC_W'(v_next[i]);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            occ_reg <= '0;
        end else begin
            occ_reg <= occ_next;
        end
    end

    assign Occupancy = occ_reg;
`endif

endmodule
